// File: rtl/mdu_hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo_pkg
// Description : Shared MDU opcode encodings, default latencies and FSM state
//               type for the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_hilo_pkg;

    // Opcode encodings shared with the instruction decoder
    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    // Default busy latencies
    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    // Sequencer states: IDLE has busy low, RUN has busy high
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage : mdu_hilo_pkg
`default_nettype wire

// File: rtl/mdu_calc.sv
`default_nettype none
// ============================================================================
// Module      : mdu_calc
// Description : Purely combinational MDU datapath. Produces the 64-bit
//               {hi_res, lo_res} result of MULT/MULTU/DIV/DIVU and flags a
//               zero divisor for the divide opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_calc
    import mdu_hilo_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_by_zero
);

    logic [63:0]        a_sext;
    logic [63:0]        b_sext;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        divisor;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic               div_ovf;

    // Products, quotients and remainders for every opcode, then select by op
    always_comb begin
        // Sign-extending to 64 bits lets one unsigned multiply give the signed product
        a_sext  = {{32{a[31]}}, a};
        b_sext  = {{32{b[31]}}, b};
        prod_s  = a_sext * b_sext;
        prod_u  = {32'd0, a} * {32'd0, b};
        // Substitute 1 for a zero divisor; the result is discarded in that case
        divisor = (b == 32'd0) ? 32'd1 : b;
        quot_s  = $signed(a) / $signed(divisor);
        rem_s   = $signed(a) % $signed(divisor);
        quot_u  = a / divisor;
        rem_u   = a % divisor;
        // Most-negative / -1 overflows; pin it to the defined wrap result
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

        hi_res      = 32'd0;
        lo_res      = 32'd0;
        div_by_zero = 1'b0;
        case (op)
            MDU_MULT: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_MULTU: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MDU_DIV: begin
                hi_res      = div_ovf ? 32'd0 : rem_s;
                lo_res      = div_ovf ? 32'h8000_0000 : quot_s;
                div_by_zero = (b == 32'd0);
            end
            MDU_DIVU: begin
                hi_res      = rem_u;
                lo_res      = quot_u;
                div_by_zero = (b == 32'd0);
            end
            default: ;
        endcase
    end

endmodule : mdu_calc
`default_nettype wire

// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : EX-stage multiply/divide unit with architectural HI/LO
//               registers. Multi-cycle MULT/MULTU/DIV/DIVU, single-cycle
//               MTHI/MTLO, busy output for the hazard unit.
//               Optional macro MDU_CANCEL_EN adds a cancel input that aborts
//               an in-flight operation and drops a concurrent start.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e        state;
    logic [CNT_W-1:0]  count;
    logic [31:0]       hi_pend;
    logic [31:0]       lo_pend;
    logic [31:0]       hi_res;
    logic [31:0]       lo_res;
    logic              div_by_zero;
    logic              cancel_now;

`ifdef MDU_CANCEL_EN
    assign cancel_now = cancel;
`else
    assign cancel_now = 1'b0;
`endif

    mdu_calc u_calc (
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_res      (hi_res),
        .lo_res      (lo_res),
        .div_by_zero (div_by_zero)
    );

    // Sequencer: accept in IDLE, count down in RUN, commit HI/LO as busy falls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            count   <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_pend <= 32'd0;
            lo_pend <= 32'd0;
        end else if (cancel_now) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            MDU_MTHI: hi <= a;
                            MDU_MTLO: lo <= a;
                            MDU_MULT, MDU_MULTU: begin
                                hi_pend <= hi_res;
                                lo_pend <= lo_res;
                                count   <= CNT_W'(MULT_CYCLES);
                                busy    <= 1'b1;
                                state   <= ST_RUN;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                // HI/LO cannot change while busy, so a zero
                                // divisor simply re-commits the current values
                                hi_pend <= div_by_zero ? hi : hi_res;
                                lo_pend <= div_by_zero ? lo : lo_res;
                                count   <= CNT_W'(DIV_CYCLES);
                                busy    <= 1'b1;
                                state   <= ST_RUN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (count == CNT_W'(1)) begin
                        hi    <= hi_pend;
                        lo    <= lo_pend;
                        count <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule : mdu_hilo
`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with the architectural HI/LO registers, in the EX stage.
- Consumes the decoder's MDU enable and 3-bit MDU opcode together with the two forwarded operands.
- Runs MULT/MULTU/DIV/DIVU as fixed multi-cycle operations and executes MTHI/MTLO in a single cycle.
- Exposes HI, LO and busy; hazard logic uses busy to stall MFHI/MFLO/MDU instructions in ID.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range >= 1).

Ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  MDU enable from the EX-stage control bundle; one-cycle pulse per instruction.
- op  in  3  MDU opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- a  in  32  rs operand, forwarded.
- b  in  32  rt operand, forwarded.
- busy  out  1  multi-cycle operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, pending result=0. All take effect immediately on reset_n low, regardless of clk.
- Accept rule: an operation is accepted only at a rising edge where start=1 and busy=0. start with busy=1 is ignored entirely; hazard logic guarantees this never occurs.
- op 0 or 7 with start=1: no-op, no state change.
- MTHI: hi<=a at the accepting edge; busy stays 0. New hi is visible the next cycle.
- MTLO: lo<=a at the accepting edge; busy stays 0. New lo is visible the next cycle.
- Multi-cycle accept at edge T:
  - Result is computed from a and b and latched into hi_pend/lo_pend.
  - Counter is loaded with N (MULT_CYCLES or DIV_CYCLES); busy<=1.
  - busy is therefore high for exactly N cycles, T+1 through T+N.
- States: IDLE (busy=0) and RUN (busy=1).
  - RUN: the counter decrements each edge.
  - At the edge where counter==1: hi<=hi_pend, lo<=lo_pend, busy<=0, return to IDLE.
  - HI/LO hold their old values for all of RUN. New values appear in the same cycle busy falls; there is no cycle with busy=0 and stale results.
- MULT: {hi,lo} = signed 64-bit product of a and b.
- MULTU: {hi,lo} = unsigned 64-bit product of a and b.
- DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Divide by zero (DIV or DIVU with b==0): busy still runs DIV_CYCLES; hi and lo are left unchanged at completion.
- hi and lo are plain register outputs with no internal bypass. Forwarding of MDU results is the hazard unit's job.
- Reset mid-operation: aborts immediately; everything returns to reset values.

Optional Feature:
- Macro: MDU_CANCEL_EN.
- When defined:
  - Adds input cancel (1 bit), for the exception/flush path.
  - cancel=1 at an edge clears busy and the counter; HI/LO are not updated.
  - If cancel and start are both high, cancel wins: the start is dropped, including MTHI/MTLO.
- When undefined: no cancel port; an operation in flight always completes.

Decomposition:
- Shared package/define file holds:
  - MDU opcode constants (none/mult/multu/div/divu/mthi/mtlo), matching the decoder's encodings.
  - Default latency constants MULT_CYCLES=5 and DIV_CYCLES=10.
- One natural sub-module, mdu_calc: purely combinational; takes op, a, b and returns 64-bit {hi_res, lo_res} plus a div_by_zero flag.
- The top level keeps the counter, the FSM and the HI/LO registers.

Test Plan:
- MULT: a=0xFFFFFFFE (-2), b=3, start at T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA after 5 busy cycles.
- DIV: a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO (busy stays 0, values visible next cycle); then DIVU with b=0 -> busy 10 cycles, hi/lo remain 0x11/0x22.
- start with MULT during busy of a DIV -> ignored: only the DIV result lands, and busy drops after exactly 10 cycles.
- reset_n pulled low mid-MULT -> busy, hi and lo go to 0 immediately, without waiting for a clock edge. With MDU_CANCEL_EN, cancel during a DIV -> busy low next cycle, HI/LO unchanged.
